decoder_stage_controller: RTL and testbench

DECODER_STAGE_CONTROLLER -- requirements
Module: decoder_stage_controller

---
 rtl/decoder_stage_controller.sv | 140 ++++++++++++++
 tb/tb_decoder_stage_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stage_controller.sv
// Round-level controller for the decoder processing units: sequences the
// MEASUREMENT_LOADING / MERGE / GROW / PEELING / RESULT_VALID stages and
// broadcasts the current stage to every PU from a register.
module decoder_stage_controller #(
    parameter int STAGE_WIDTH   = 3,
    parameter int LOAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_ITER      = 63,
    parameter int ITER_WIDTH    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic                   busy_any,
    input  logic                   odd_any,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout
);

    typedef enum logic [STAGE_WIDTH-1:0] {
        ST_IDLE   = STAGE_WIDTH'(0),
        ST_GROW   = STAGE_WIDTH'(1),
        ST_MERGE  = STAGE_WIDTH'(2),
        ST_PEEL   = STAGE_WIDTH'(3),
        ST_LOAD   = STAGE_WIDTH'(4),
        ST_RESULT = STAGE_WIDTH'(5)
    } stage_e;

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LW-1:0]         LOAD_LAST   = LW'(LOAD_CYCLES - 1);
    localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_MAX    = ITER_WIDTH'(MAX_ITER);

    stage_e                state_q, state_d;
    logic [LW-1:0]         load_q, load_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic                  timeout_q, timeout_d;
    logic                  settled;

    // The settle window covers the first SETTLE_CYCLES-1 cycles of a state;
    // the last of the SETTLE_CYCLES cycles is the first one allowed to decide.
    assign settled = (settle_q >= SETTLE_LAST);

    // Next-state, counter and result-flag logic.
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        settle_d  = settle_q;
        iter_d    = iter_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d   = ST_LOAD;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_q == LOAD_LAST) begin
                    state_d = ST_MERGE;
                end else begin
                    load_d = load_q + LW'(1);
                end
            end
            ST_MERGE: begin
                if (settled && !busy_any) begin
                    if (odd_any && (iter_q < ITER_MAX)) begin
                        state_d = ST_GROW;
                    end else begin
                        state_d = ST_PEEL;
                        // Still odd clusters at the iteration cap: give up.
                        if (odd_any) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
            end
            ST_GROW: begin
                // Always a single cycle: PUs grow on the edge of this pulse.
                state_d = ST_MERGE;
                if (iter_q < ITER_MAX) begin
                    iter_d = iter_q + ITER_WIDTH'(1);
                end
            end
            ST_PEEL: begin
                if (settled && !busy_any) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the load and settle counters.
        if (state_d != state_q) begin
            settle_d = '0;
            load_d   = '0;
        end else if ((state_q == ST_MERGE || state_q == ST_PEEL) && !settled) begin
            settle_d = settle_q + SW'(1);
        end
    end

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            load_q    <= '0;
            settle_q  <= '0;
            iter_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            settle_q  <= settle_d;
            iter_q    <= iter_d;
            timeout_q <= timeout_d;
        end
    end

    assign global_stage    = state_q;
    assign start_ready     = (state_q == ST_IDLE);
    assign result_valid    = (state_q == ST_RESULT);
    assign iteration_count = iter_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench for decoder_stage_controller: expected stage traces are
// queued when a round is launched and popped one per clock.
module tb_decoder_stage_controller;

    localparam int SW   = 3;
    localparam int IW   = 6;
    localparam int MAXI = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic          busy_any;
    logic          odd_any;
    logic [SW-1:0] global_stage;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] iteration_count;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];

    always #5 clk = ~clk;

    decoder_stage_controller #(
        .STAGE_WIDTH  (SW),
        .LOAD_CYCLES  (2),
        .SETTLE_CYCLES(3),
        .MAX_ITER     (MAXI),
        .ITER_WIDTH   (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .busy_any       (busy_any),
        .odd_any        (odd_any),
        .global_stage   (global_stage),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .iteration_count(iteration_count),
        .timeout        (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [SW-1:0] st, input int n);
        repeat (n) exp_q.push_back(st);
    endtask

    task automatic test_reset();
        reset = 1'b0; start_valid = 1'b0; busy_any = 1'b0; odd_any = 1'b0; result_ready = 1'b0;
        #3;
        checks++;
        if (global_stage !== 3'd0 || start_ready !== 1'b1 || result_valid !== 1'b0 ||
            iteration_count !== 6'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: stage=%0d rdy=%b rv=%b iter=%0d to=%b, expected 0/1/0/0/0",
                     global_stage, start_ready, result_valid, iteration_count, timeout);
        end
        start_valid = 1'b1;
        step();
        checks++;
        if (global_stage !== 3'd0) begin
            errors++;
            $display("FAIL reset_holds_idle: stage=%0d expected 0", global_stage);
        end
        reset = 1'b1; start_valid = 1'b0;
        step();
        checks++;
        if (global_stage !== 3'd0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_release: stage=%0d rdy=%b expected 0/1", global_stage, start_ready);
        end
    endtask

    task automatic release_result(input string name);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        checks++;
        if (global_stage !== 3'd0 || result_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: stage=%0d rv=%b rdy=%b expected 0/0/1",
                     name, global_stage, result_valid, start_ready);
        end
    endtask

    task automatic test_basic();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2); push_run(3'd2, 3); push_run(3'd3, 3); push_run(3'd5, 1);
        start_valid = 1'b1; odd_any = 1'b0; busy_any = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e || result_valid !== (e == 3'd5) || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_cycle%0d: stage=%0d rv=%b rdy=%b expected stage %0d",
                         k, global_stage, result_valid, start_ready, e);
            end
        end
        checks++;
        if (k != 9 || iteration_count !== 6'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: cycles=%0d iter=%0d to=%b expected 9/0/0", k, iteration_count, timeout);
        end
        release_result("basic");
    endtask

    task automatic test_grow_two();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2); push_run(3'd2, 3); push_run(3'd1, 1); push_run(3'd2, 3);
        push_run(3'd1, 1); push_run(3'd2, 3); push_run(3'd3, 3); push_run(3'd5, 1);
        start_valid = 1'b1; odd_any = 1'b1; busy_any = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            odd_any = (k < 10);
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e) begin
                errors++;
                $display("FAIL grow2_cycle%0d: stage=%0d expected %0d", k, global_stage, e);
            end
        end
        checks++;
        if (iteration_count !== 6'd2 || timeout !== 1'b0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL grow2_result: iter=%0d to=%b rv=%b expected 2/0/1", iteration_count, timeout, result_valid);
        end
        release_result("grow2");
    endtask

    task automatic test_timeout();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2);
        repeat (3) begin push_run(3'd2, 3); push_run(3'd1, 1); end
        push_run(3'd2, 3); push_run(3'd3, 3); push_run(3'd5, 1);
        start_valid = 1'b1; odd_any = 1'b1; busy_any = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e || (e == 3'd1 && timeout !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_cycle%0d: stage=%0d to=%b expected stage %0d", k, global_stage, timeout, e);
            end
        end
        checks++;
        if (iteration_count !== 6'd3 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: iter=%0d to=%b expected 3/1", iteration_count, timeout);
        end
        odd_any = 1'b0;
        release_result("timeout");
    endtask

    task automatic test_busy_hold();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2); push_run(3'd2, 13); push_run(3'd3, 3); push_run(3'd5, 1);
        start_valid = 1'b1; odd_any = 1'b0; busy_any = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            // odd and busy toggle inside settle windows; busy high for 10 decision cycles
            odd_any  = (k == 3) || (k == 4) || (k == 17);
            busy_any = (k == 4) || (k >= 5 && k <= 14) || (k == 16);
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e) begin
                errors++;
                $display("FAIL busy_cycle%0d: stage=%0d expected %0d", k, global_stage, e);
            end
            if (k == 1) begin
                checks++;
                if (iteration_count !== 6'd0 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_accept_clear: iter=%0d to=%b expected 0/0", iteration_count, timeout);
                end
            end
        end
        odd_any = 1'b0; busy_any = 1'b0;
        checks++;
        if (iteration_count !== 6'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL busy_result: iter=%0d to=%b expected 0/0", iteration_count, timeout);
        end
        release_result("busy");
    endtask

    task automatic test_result_hold();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2); push_run(3'd2, 3); push_run(3'd1, 1); push_run(3'd2, 3);
        push_run(3'd3, 3); push_run(3'd5, 1);
        start_valid = 1'b1; odd_any = 1'b1; busy_any = 1'b0; result_ready = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid  = 1'b0;
            odd_any      = (k < 6);
            result_ready = (k < 3);
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e) begin
                errors++;
                $display("FAIL hold_cycle%0d: stage=%0d expected %0d", k, global_stage, e);
            end
        end
        result_ready = 1'b0; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (global_stage !== 3'd5 || result_valid !== 1'b1 || start_ready !== 1'b0 ||
                iteration_count !== 6'd1 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_wait%0d: stage=%0d rv=%b rdy=%b iter=%0d to=%b expected 5/1/0/1/0",
                         i, global_stage, result_valid, start_ready, iteration_count, timeout);
            end
        end
        start_valid = 1'b0;
        release_result("hold");
        step();
        checks++;
        if (global_stage !== 3'd0) begin
            errors++;
            $display("FAIL hold_no_start: stage=%0d expected 0", global_stage);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        logic [SW-1:0] e;
        push_run(3'd4, 2); push_run(3'd2, 3); push_run(3'd1, 1); push_run(3'd2, 3); push_run(3'd1, 1);
        start_valid = 1'b1; odd_any = 1'b1; busy_any = 1'b0;
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e) begin
                errors++;
                $display("FAIL rstmid_cycle%0d: stage=%0d expected %0d", k, global_stage, e);
            end
        end
        checks++;
        if (iteration_count !== 6'd1) begin
            errors++;
            $display("FAIL rstmid_pre_iter: iter=%0d expected 1", iteration_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (global_stage !== 3'd0 || start_ready !== 1'b1 || result_valid !== 1'b0 ||
            iteration_count !== 6'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: stage=%0d rdy=%b rv=%b iter=%0d to=%b expected 0/1/0/0/0",
                     global_stage, start_ready, result_valid, iteration_count, timeout);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (global_stage !== 3'd0 || result_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_hold%0d: stage=%0d rv=%b expected 0/0", i, global_stage, result_valid);
            end
        end
        reset = 1'b1; start_valid = 1'b1; odd_any = 1'b0;
        k = 0;
        push_run(3'd4, 2); push_run(3'd2, 3); push_run(3'd3, 3); push_run(3'd5, 1);
        while (exp_q.size() > 0) begin
            step(); k++;
            start_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (global_stage !== e) begin
                errors++;
                $display("FAIL rstmid_new_cycle%0d: stage=%0d expected %0d", k, global_stage, e);
            end
        end
        checks++;
        if (iteration_count !== 6'd0 || timeout !== 1'b0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_new_result: iter=%0d to=%b rv=%b expected 0/0/1", iteration_count, timeout, result_valid);
        end
        release_result("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grow_two();
        test_timeout();
        test_busy_hold();
        test_result_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
